// File: rtl/datapath_if.sv
// datapath_if: control-unit side signals of the single-bus datapath.
interface datapath_if;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic [31:0] inPort;
  logic [31:0] MDataIn;
  logic        MD_Read;
  logic [3:0]  Control_Signals;
  logic [31:0] busMuxOut;
  modport master (output enable, busSelect, inPort, MDataIn, MD_Read, Control_Signals, input busMuxOut);
  modport slave  (input enable, busSelect, inPort, MDataIn, MD_Read, Control_Signals, output busMuxOut);
endinterface

// File: rtl/datapath.sv
// datapath: 32-bit single-bus CPU datapath with register file, HI/LO/Y/Z, PC, IR, MAR, MDR, InPort and ALU.
module datapath (
  input logic       clk,
  input logic       clr,
  datapath_if.slave bus
);
  logic [31:0] r_rf [15:1];
  logic [31:0] r_hi, r_lo, r_y, r_pc, r_ir, r_mar, r_mdr, r_inport;
  logic [63:0] r_z;
  logic [31:0] w_bus;
  logic [63:0] w_alu;
  logic [4:0]  w_sh;
  logic signed [63:0] w_mul;
  logic signed [31:0] w_quo, w_rem;
  logic        w_unused;
  assign w_sh      = w_bus[4:0];
  assign w_mul     = $signed(r_y) * $signed(w_bus);
  assign w_quo     = $signed(r_y) / $signed(w_bus);
  assign w_rem     = $signed(r_y) % $signed(w_bus);
  assign w_unused  = ^{r_mar, r_ir[31:19]};
  assign bus.busMuxOut = w_bus;
  always_comb begin
    w_bus = '0;
    case (bus.busSelect)
      32'd16:  w_bus = r_hi;
      32'd17:  w_bus = r_lo;
      32'd18:  w_bus = r_z[63:32];
      32'd19:  w_bus = r_z[31:0];
      32'd20:  w_bus = r_pc;
      32'd21:  w_bus = r_mdr;
      32'd22:  w_bus = r_inport;
      32'd23:  w_bus = {{13{r_ir[18]}}, r_ir[18:0]};
      default: w_bus = (bus.busSelect >= 32'd1 && bus.busSelect <= 32'd15) ? r_rf[bus.busSelect[3:0]] : '0;
    endcase
  end
  always_comb begin
    w_alu = '0;
    case (bus.Control_Signals)
      4'd0:  w_alu = {32'd0, r_y + w_bus};
      4'd1:  w_alu = {32'd0, r_y - w_bus};
      4'd2:  w_alu = {32'd0, r_y & w_bus};
      4'd3:  w_alu = {32'd0, r_y | w_bus};
      4'd4:  w_alu = {32'd0, ~w_bus};
      4'd5:  w_alu = {32'd0, -w_bus};
      4'd6:  w_alu = {32'd0, r_y >> w_sh};
      4'd7:  w_alu = {32'd0, $signed(r_y) >>> w_sh};
      4'd8:  w_alu = {32'd0, r_y << w_sh};
      4'd9:  w_alu = {32'd0, (r_y >> w_sh) | (r_y << (6'd32 - {1'b0, w_sh}))};
      4'd10: w_alu = {32'd0, (r_y << w_sh) | (r_y >> (6'd32 - {1'b0, w_sh}))};
      4'd11: w_alu = w_mul;
      4'd12: w_alu = (w_bus == 32'd0) ? 64'd0 : {w_rem, w_quo};
      4'd13: w_alu = {32'd0, w_bus};
      4'd14: w_alu = {32'd0, r_y};
      default: w_alu = {32'd0, w_bus + 32'd1};
    endcase
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 1; i < 16; i++) r_rf[i] <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_pc     <= '0;
      r_ir     <= '0;
      r_mar    <= '0;
      r_mdr    <= '0;
      r_inport <= '0;
    end else begin
      for (int i = 1; i < 16; i++) if (bus.enable == 32'(i)) r_rf[i] <= w_bus;
      if (bus.enable == 32'd16) r_hi     <= w_bus;
      if (bus.enable == 32'd17) r_lo     <= w_bus;
      if (bus.enable == 32'd18) r_y      <= w_bus;
      if (bus.enable == 32'd20) r_pc     <= w_bus;
      if (bus.enable == 32'd21) r_mdr    <= bus.MD_Read ? bus.MDataIn : w_bus;
      if (bus.enable == 32'd22) r_inport <= bus.inPort;
      if (bus.enable == 32'd23) r_ir     <= w_bus;
      if (bus.enable == 32'd24) r_z      <= w_alu;
      if (bus.enable == 32'd25) r_mar    <= w_bus;
    end
  end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed scenarios plus random transfers checked against a register-level model.
module tb_datapath;
  logic clk = 1'b0;
  logic clr;
  datapath_if bus_if ();
  datapath dut (.clk(clk), .clr(clr), .bus(bus_if.slave));
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m [0:31];
  logic [63:0] mz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mbus(input int sel);
    if ((sel >= 1 && sel <= 17) || (sel >= 20 && sel <= 22)) return m[sel];
    if (sel == 18) return mz[63:32];
    if (sel == 19) return mz[31:0];
    if (sel == 23) return {{13{m[23][18]}}, m[23][18:0]};
    return 32'd0;
  endfunction

  function automatic logic [63:0] malu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    int s = int'(b[4:0]);
    logic [31:0] t = a;
    case (op)
      0: return (longint'(a) + longint'(b)) & 64'hFFFF_FFFF;
      1: return (longint'(a) - longint'(b)) & 64'hFFFF_FFFF;
      2: return {32'd0, a & b};
      3: return {32'd0, a | b};
      4: return {32'd0, ~b};
      5: return (64'd0 - longint'(b)) & 64'hFFFF_FFFF;
      6: return longint'(a) / (64'd1 << s);
      7: return (sa >>> s) & 64'hFFFF_FFFF;
      8: return (longint'(a) * (64'd1 << s)) & 64'hFFFF_FFFF;
      9: begin
        repeat (s) t = {t[0], t[31:1]};
        return {32'd0, t};
      end
      10: begin
        repeat (s) t = {t[30:0], t[31]};
        return {32'd0, t};
      end
      11: return sa * sb;
      12: return (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      13: return {32'd0, b};
      14: return {32'd0, a};
      default: return (longint'(b) + 1) & 64'hFFFF_FFFF;
    endcase
  endfunction

  task automatic mclear();
    for (int i = 0; i < 32; i++) m[i] = '0;
    mz = '0;
  endtask

  task automatic cyc(input int en, input int sel);
    logic [31:0] b;
    bus_if.enable = 32'(en);
    bus_if.busSelect = 32'(sel);
    #1;
    b = mbus(sel);
    chk($sformatf("bus sel=%0d", sel), {32'd0, bus_if.busMuxOut}, {32'd0, b});
    @(posedge clk);
    if ((en >= 1 && en <= 18) || en == 20 || en == 23 || en == 25) m[en] = b;
    if (en == 21) m[21] = bus_if.MD_Read ? bus_if.MDataIn : b;
    if (en == 22) m[22] = bus_if.inPort;
    if (en == 24) mz = malu(int'(bus_if.Control_Signals), m[18], b);
    #1;
  endtask

  task automatic look(input string tag, input int sel, input logic [31:0] exp);
    bus_if.enable = '0;
    bus_if.busSelect = 32'(sel);
    #1;
    chk(tag, {32'd0, bus_if.busMuxOut}, {32'd0, exp});
  endtask

  task automatic load(input int code, input logic [31:0] val);
    bus_if.MDataIn = val;
    bus_if.MD_Read = 1'b1;
    cyc(21, 0);
    bus_if.MD_Read = 1'b0;
    cyc(code, 21);
  endtask

  initial begin
    clr = 1'b1;
    bus_if.enable = '0;
    bus_if.busSelect = '0;
    bus_if.inPort = '0;
    bus_if.MDataIn = '0;
    bus_if.MD_Read = 1'b0;
    bus_if.Control_Signals = '0;
    mclear();
    repeat (2) @(posedge clk);
    for (int c = 0; c < 32; c++) look($sformatf("reset sel=%0d", c), c, 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    load(2, 32'h12);
    look("s2_r2", 2, 32'h12);
    load(1, 32'h18);
    bus_if.Control_Signals = 4'd4;
    cyc(24, 1);
    look("s3_not_zlo", 19, 32'hFFFF_FFE7);
    look("s3_not_zhi", 18, 32'd0);
    cyc(18, 2);
    load(3, 32'h14);
    bus_if.Control_Signals = 4'd3;
    cyc(24, 3);
    look("s4_or_zlo", 19, 32'h16);
    load(18, 32'hFFFF_FFFE);
    load(4, 32'd3);
    bus_if.Control_Signals = 4'd11;
    cyc(24, 4);
    look("s5_mul_zhi", 18, 32'hFFFF_FFFF);
    look("s5_mul_zlo", 19, 32'hFFFF_FFFA);
    load(18, 32'd7);
    load(4, 32'd2);
    bus_if.Control_Signals = 4'd12;
    cyc(24, 4);
    look("s5_div_quo", 19, 32'd3);
    look("s5_div_rem", 18, 32'd1);
    cyc(24, 0);
    look("s5_div0_zlo", 19, 32'd0);
    look("s5_div0_zhi", 18, 32'd0);
    load(20, 32'd5);
    bus_if.Control_Signals = 4'd15;
    cyc(25, 20);
    chk("s6_mar", {32'd0, dut.r_mar}, 64'd5);
    cyc(24, 20);
    look("s6_inc_zlo", 19, 32'd6);
    cyc(20, 19);
    look("s6_pc", 20, 32'd6);
    #2 clr = 1'b1;
    #1 chk("s6_async_pc", {32'd0, bus_if.busMuxOut}, 64'd0);
    mclear();
    @(posedge clk);
    #1 clr = 1'b0;
    load(2, 32'h55);
    bus_if.enable = 32'd2;
    bus_if.busSelect = 32'd21;
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    mclear();
    look("clr_wins_r2", 2, 32'd0);
    look("clr_wins_mdr", 21, 32'd0);
    for (int k = 0; k < 400; k++) begin
      int en, sel;
      bus_if.MDataIn = $urandom;
      bus_if.inPort = $urandom;
      bus_if.MD_Read = 1'($urandom_range(0, 1));
      bus_if.Control_Signals = 4'($urandom_range(0, 15));
      en = int'($urandom_range(0, 27));
      sel = int'($urandom_range(0, 27));
      if (bus_if.Control_Signals == 4'd12 && m[18] == 32'h8000_0000 && mbus(sel) == 32'hFFFF_FFFF)
        bus_if.Control_Signals = 4'd13;
      cyc(en, sel);
    end
    for (int c = 0; c < 28; c++) look($sformatf("final sel=%0d", c), c, mbus(c));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
